// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, segment encodings and conversion state type for the operand display.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 12;
    localparam logic [9:0] MAG_MAX = 10'd999;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = SEG_0;
            4'd1:    seg_of = SEG_1;
            4'd2:    seg_of = SEG_2;
            4'd3:    seg_of = SEG_3;
            4'd4:    seg_of = SEG_4;
            4'd5:    seg_of = SEG_5;
            4'd6:    seg_of = SEG_6;
            4'd7:    seg_of = SEG_7;
            4'd8:    seg_of = SEG_8;
            4'd9:    seg_of = SEG_9;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, 10-bit binary to 12-bit BCD in LOAD + 10 SHIFT + DONE cycles.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [9:0]       i_bin,
    output logic             o_busy,
    output logic             o_load,
    output logic             o_done,
    output logic [BCD_W-1:0] o_bcd
);

    state_t             r_state;
    logic [BCD_W+9:0]   r_sr;
    logic [3:0]         r_cnt;
    logic [BCD_W-1:0]   w_adj;

    always_comb begin
        w_adj = '0;
        for (int k = 0; k < BCD_W / 4; k++)
            w_adj[4*k +: 4] = r_sr[10+4*k +: 4] >= 4'd5 ? r_sr[10+4*k +: 4] + 4'd3 : r_sr[10+4*k +: 4];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            o_busy  <= 1'b0;
            o_load  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_load <= 1'b0;
            o_done <= 1'b0;
            case (r_state)
                IDLE: if (i_start) begin
                    r_state <= LOAD;
                    o_busy  <= 1'b1;
                    o_load  <= 1'b1;
                end
                LOAD: begin
                    r_sr    <= {{BCD_W{1'b0}}, i_bin};
                    r_cnt   <= '0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_sr  <= {w_adj, r_sr[9:0]} << 1;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd9) begin
                        r_state <= DONE;
                        o_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_bcd = r_sr[BCD_W+9:10];

endmodule

// File: rtl/seg7_operand_display.sv
// seg7_operand_display: signed operand to sign-magnitude BCD, multiplexed onto a 4-digit common-anode display.
// Define SEG7_BLINK_EN to blink the digit selected by i_unit.
module seg7_operand_display
    import seg7_pkg::*;
#(
    parameter int VALUE_W     = 16,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [VALUE_W-1:0]    i_value,
    input  logic [1:0]            i_unit,
    input  logic                  i_operand_sel,
    output logic [NUM_DIGITS-1:0] o_an,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic                  o_busy,
    output logic                  o_ovf
);

    localparam int SCAN_W = $clog2(REFRESH_DIV);

    logic [VALUE_W:0]   w_ext, w_abs;
    logic               w_ovf, w_busy, w_load, w_done, w_start, w_wrap, w_blank;
    logic [9:0]         w_mag;
    logic [BCD_W-1:0]   w_bcd;
    logic [3:0]         w_nib;
    logic [6:0]         w_seg;
    logic [VALUE_W-1:0] r_cap;
    logic               r_sign_n, r_ovf_n, r_sign, r_ovf;
    logic [BCD_W-1:0]   r_bcd;
    logic [SCAN_W-1:0]  r_scan;
    logic [1:0]         r_digit;

    // One extra bit so the magnitude of the most negative value is representable.
    assign w_ext   = {i_value[VALUE_W-1], i_value};
    assign w_abs   = w_ext[VALUE_W] ? -w_ext : w_ext;
    assign w_ovf   = w_abs > (VALUE_W+1)'(MAG_MAX);
    assign w_mag   = w_ovf ? MAG_MAX : w_abs[9:0];
    assign w_start = !w_busy && (i_value != r_cap);

    bin2bcd_seq u_bcd (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_start),
        .i_bin   (w_mag),
        .o_busy  (w_busy),
        .o_load  (w_load),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cap    <= '0;
            r_sign_n <= 1'b0;
            r_ovf_n  <= 1'b0;
            r_bcd    <= '0;
            r_sign   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_load) begin
                r_cap    <= i_value;
                r_sign_n <= i_value[VALUE_W-1];
                r_ovf_n  <= w_ovf;
            end
            if (w_done) begin
                r_bcd  <= w_bcd;
                r_sign <= r_sign_n;
                r_ovf  <= r_ovf_n;
            end
        end
    end

    assign w_wrap = r_scan == SCAN_W'(REFRESH_DIV - 1);
    assign w_nib  = r_digit == 2'd2 ? r_bcd[11:8] : r_digit == 2'd1 ? r_bcd[7:4] : r_bcd[3:0];
    assign w_seg  = r_digit == 2'd3 ? (r_sign ? SEG_MINUS : SEG_BLANK) : seg_of(w_nib);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan  <= '0;
            r_digit <= '0;
            o_an    <= '1;
            o_seg   <= SEG_BLANK;
            o_dp    <= 1'b1;
        end else begin
            r_scan  <= w_wrap ? '0 : r_scan + SCAN_W'(1);
            r_digit <= r_digit + {1'b0, w_wrap};
            o_an    <= ~(NUM_DIGITS'(1) << r_digit);
            o_seg   <= w_blank ? SEG_BLANK : w_seg;
            o_dp    <= w_blank || !(r_digit == 2'd3 && i_operand_sel);
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV);

    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_phase;
    logic [1:0]         r_unit;

    // i_unit is sampled on digit change so a new selection never cuts a digit slot short.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_unit      <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt == BLINK_W'(BLINK_DIV - 1) ? '0 : r_blink_cnt + BLINK_W'(1);
            if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1))
                r_phase <= !r_phase;
            if (w_wrap)
                r_unit <= i_unit;
        end
    end

    assign w_blank = r_phase && (r_digit == r_unit);
`else
    localparam int unused_blink_div = BLINK_DIV;
    logic w_unused;
    assign w_unused = ^i_unit;
    assign w_blank  = 1'b0;
`endif

    assign o_busy = w_busy;
    assign o_ovf  = r_ovf;

endmodule
